// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction filter, collision and score FSM.
// Define SNAKE_WRAP_EN to make walls wrap modulo 8 instead of ending the game.
module snake_game_ctrl #(
    parameter int TICK_DIV  = 8,
    parameter int CNT_W     = 24,
    parameter int WIN_SCORE = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    input  logic [2:0] head_x,
    input  logic [2:0] head_y,
    input  logic [2:0] body1_x,
    input  logic [2:0] body1_y,
    input  logic [2:0] body2_x,
    input  logic [2:0] body2_y,
    input  logic [2:0] food_x,
    input  logic [2:0] food_y,
    output logic       move_enable,
    output logic [1:0] direction,
    output logic       grow,
    output logic       food_req,
    output logic       body_reset,
    output logic [3:0] score,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       WIN_S   = 4'(WIN_SCORE);

    state_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       score_q, score_d;
    logic             move_q, move_d;
    logic             grow_q, grow_d;
    logic             food_q, food_d;
    logic             brst_q, brst_d;

    logic       tick;
    logic       wall;
    logic       eat;
    logic       self_hit;
    logic       dir_ok;
    logic [2:0] nx, ny;

    assign tick = (state_q == S_RUN) && (cnt_q == CNT_MAX);

    always_comb begin
        nx = head_x;
        ny = head_y;
        unique case (pend_q)
            2'b00: ny = head_y - 3'd1;
            2'b01: ny = head_y + 3'd1;
            2'b10: nx = head_x - 3'd1;
            2'b11: nx = head_x + 3'd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall = 1'b0;
`else
    always_comb begin
        wall = 1'b0;
        unique case (pend_q)
            2'b00: wall = (head_y == 3'd0);
            2'b01: wall = (head_y == 3'd7);
            2'b10: wall = (head_x == 3'd0);
            2'b11: wall = (head_x == 3'd7);
        endcase
    end
`endif

    assign eat = (nx == food_x) && (ny == food_y);
    // Without growth the tail cell is vacated on this move, so it only blocks when eating.
    assign self_hit = ((nx == body1_x) && (ny == body1_y))
                    || ((nx == body2_x) && (ny == body2_y) && eat);

    assign dir_ok = dir_req_valid
                  && ((state_q == S_RUN) || (state_q == S_PAUSE))
                  && !((dir_req[1] == dir_q[1]) && (dir_req[0] != dir_q[0]));

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        move_d  = 1'b0;
        grow_d  = 1'b0;
        food_d  = 1'b0;
        brst_d  = 1'b0;
        if (dir_ok) begin
            pend_d = dir_req;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (pause) begin
                    state_d = S_PAUSE;
                end
                if (tick) begin
                    if (wall || self_hit) begin
                        state_d = S_OVER;
                    end else begin
                        move_d = 1'b1;
                        grow_d = eat;
                        dir_d  = pend_q;
                    end
                end
            end
            S_PAUSE: begin
                if (pause) begin
                    state_d = S_RUN;
                end
            end
            S_OVER, S_WIN: begin
                if (start) begin
                    state_d = S_IDLE;
                    brst_d  = 1'b1;
                    score_d = '0;
                    dir_d   = 2'b01;
                    pend_d  = 2'b01;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Food follow-up runs the cycle after a growing move.
        if (move_q && grow_q) begin
            food_d = 1'b1;
            if (score_q != 4'd15) begin
                score_d = score_q + 4'd1;
            end
            if (score_d == WIN_S) begin
                state_d = S_WIN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 2'b01;
            pend_q  <= 2'b01;
            cnt_q   <= '0;
            score_q <= '0;
            move_q  <= 1'b0;
            grow_q  <= 1'b0;
            food_q  <= 1'b0;
            brst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            move_q  <= move_d;
            grow_q  <= grow_d;
            food_q  <= food_d;
            brst_q  <= brst_d;
        end
    end

    assign move_enable = move_q;
    assign direction   = dir_q;
    assign grow        = grow_q;
    assign food_req    = food_q;
    assign body_reset  = brst_q;
    assign score       = score_q;
    assign state       = state_q;

endmodule
